// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler
//
// Purpose:
//   Turns the free-running display counter into game timing. A rising edge
//   of display_cnt[WRAP_BIT] is one frame. Each frame produces a one-cycle
//   frame_tick. Per-actor frame dividers derive the Pacman, Blinky and Clyde
//   move strobes from these frames. Pacman's mouth animation steps once per
//   Pacman move.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   display_cnt  in   [CNT_W-1:0] free-running display counter value
//   pause        in   level; freezes movement and animation (ticks continue)
//   frightened   in   level; ghosts divide by FRIGHT_DIV instead of GHOST_DIV
//   step         in   (SINGLE_STEP_EN only) rising edge injects one frame
//                     while paused
//   frame_tick   out  one-cycle pulse per counter wrap
//   pac_move     out  one-cycle Pacman move strobe
//   blinky_move  out  one-cycle Blinky move strobe
//   clyde_move   out  one-cycle Clyde move strobe
//   mouth_state  out  [1:0] 0=OPEN 1=HALF_CLOSING 2=CLOSED 3=HALF_OPENING
//
// Build option:
//   SINGLE_STEP_EN  when defined, adds the `step` input for single-frame
//                   stepping while paused. When undefined, pause fully
//                   freezes movement.
// ---------------------------------------------------------------------------
module move_scheduler #(
  parameter int CNT_W      = 27,
  parameter int WRAP_BIT   = 25,
  parameter int PAC_DIV    = 1,
  parameter int GHOST_DIV  = 2,
  parameter int FRIGHT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] display_cnt,
  input  logic             pause,
  input  logic             frightened,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             frame_tick,
  output logic             pac_move,
  output logic             blinky_move,
  output logic             clyde_move,
  output logic [1:0]       mouth_state
);

  // -------------------------------------------------------------------------
  // Divider counter sizing: wide enough for the largest divisor's DIV-1.
  // -------------------------------------------------------------------------
  localparam int MAX_GDIV = (GHOST_DIV > FRIGHT_DIV) ? GHOST_DIV : FRIGHT_DIV;
  localparam int MAX_DIV  = (PAC_DIV > MAX_GDIV) ? PAC_DIV : MAX_GDIV;
  localparam int DIV_W    = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [DIV_W-1:0] PAC_LAST    = DIV_W'(PAC_DIV - 1);
  localparam logic [DIV_W-1:0] GHOST_LAST  = DIV_W'(GHOST_DIV - 1);
  localparam logic [DIV_W-1:0] FRIGHT_LAST = DIV_W'(FRIGHT_DIV - 1);
  localparam logic [DIV_W-1:0] GHOST_HALF  = DIV_W'(GHOST_DIV / 2);
  localparam logic [DIV_W-1:0] FRIGHT_HALF = DIV_W'(FRIGHT_DIV / 2);

  // Actor slots in the packed counter / strobe vectors.
  localparam int A_PAC    = 0;
  localparam int A_BLINKY = 1;
  localparam int A_CLYDE  = 2;

  typedef enum logic [1:0] {
    MOUTH_OPEN         = 2'd0,
    MOUTH_HALF_CLOSING = 2'd1,
    MOUTH_CLOSED       = 2'd2,
    MOUTH_HALF_OPENING = 2'd3
  } mouth_t;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic                  prev_bit_q;
  logic                  prev_fright_q;
  logic                  frame_tick_q;
  logic [2:0]            move_q;
  logic [2:0]            move_d;
  logic [2:0][DIV_W-1:0] cnt_q;
  logic [2:0][DIV_W-1:0] cnt_d;
  mouth_t                mouth_q;
  mouth_t                mouth_d;

  logic                  wrap_edge;
  logic                  step_evt;
  logic                  frame_evt;
  logic                  advance;
  logic                  fright_change;
  logic [DIV_W-1:0]      ghost_last;
  logic [DIV_W-1:0]      ghost_half;

  // Only WRAP_BIT matters; the remaining counter bits are deliberately
  // folded into a sink so the full-width port can stay as-is.
  logic                  unused_cnt_bits;
  assign unused_cnt_bits = ^display_cnt;

  // -------------------------------------------------------------------------
  // Frame event detection
  // -------------------------------------------------------------------------
  assign wrap_edge = display_cnt[WRAP_BIT] & ~prev_bit_q;

`ifdef SINGLE_STEP_EN
  logic step_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step;
    end
  end

  // A step only counts while paused; when running it is ignored entirely.
  assign step_evt = pause & step & ~step_prev_q;
`else
  assign step_evt = 1'b0;
`endif

  // A real wrap and a step in the same cycle merge into one frame.
  assign frame_evt = wrap_edge | step_evt;

  // While paused only synthetic step frames move anything; real wraps still
  // produce frame_tick but leave the dividers alone.
  assign advance = pause ? step_evt : wrap_edge;

  // -------------------------------------------------------------------------
  // Ghost divisor selection
  // -------------------------------------------------------------------------
  assign fright_change = frightened ^ prev_fright_q;
  assign ghost_last    = frightened ? FRIGHT_LAST : GHOST_LAST;
  assign ghost_half    = frightened ? FRIGHT_HALF : GHOST_HALF;

  // -------------------------------------------------------------------------
  // Divider next-state and strobe generation
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d  = cnt_q;
    move_d = '0;

    // Pacman ignores frightened entirely.
    if (advance) begin
      if (cnt_q[A_PAC] == PAC_LAST) begin
        cnt_d[A_PAC]  = '0;
        move_d[A_PAC] = 1'b1;
      end else begin
        cnt_d[A_PAC] = cnt_q[A_PAC] + DIV_W'(1);
      end
    end

    // A divisor change restarts both ghosts with the stagger recomputed for
    // the new divisor. It takes priority over a coincident frame, so no
    // ghost strobe is emitted from a half-old/half-new schedule.
    if (fright_change) begin
      cnt_d[A_BLINKY] = '0;
      cnt_d[A_CLYDE]  = ghost_half;
    end else if (advance) begin
      for (int i = A_BLINKY; i <= A_CLYDE; i++) begin
        if (cnt_q[i] == ghost_last) begin
          cnt_d[i]  = '0;
          move_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_bit_q      <= 1'b0;
      prev_fright_q   <= 1'b0;
      frame_tick_q    <= 1'b0;
      move_q          <= '0;
      cnt_q[A_PAC]    <= '0;
      cnt_q[A_BLINKY] <= '0;
      // Clyde starts half a ghost period ahead so the ghosts alternate.
      cnt_q[A_CLYDE]  <= GHOST_HALF;
    end else begin
      prev_bit_q    <= display_cnt[WRAP_BIT];
      prev_fright_q <= frightened;
      frame_tick_q  <= frame_evt;
      move_q        <= move_d;
      cnt_q         <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Mouth animation FSM: steps on the same edge that registers pac_move.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mouth_q <= MOUTH_OPEN;
    end else begin
      mouth_q <= mouth_d;
    end
  end

  always_comb begin
    mouth_d = mouth_q;
    if (move_d[A_PAC]) begin
      unique case (mouth_q)
        MOUTH_OPEN:         mouth_d = MOUTH_HALF_CLOSING;
        MOUTH_HALF_CLOSING: mouth_d = MOUTH_CLOSED;
        MOUTH_CLOSED:       mouth_d = MOUTH_HALF_OPENING;
        MOUTH_HALF_OPENING: mouth_d = MOUTH_OPEN;
        default:            mouth_d = MOUTH_OPEN;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign frame_tick  = frame_tick_q;
  assign pac_move    = move_q[A_PAC];
  assign blinky_move = move_q[A_BLINKY];
  assign clyde_move  = move_q[A_CLYDE];
  assign mouth_state = mouth_q;

endmodule
